fifo_11b_src_arbiter: RTL



---
 rtl/fifo_11b_src_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fifo_11b_src_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_11b_src_arbiter                                                       |
// | Four-source round-robin writer plus show-ahead reader for an 11b x 256     |
// | FIFO. Optional per-source grant counters when FIFO_ARB_STATS_EN is defined.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_11b_src_arbiter #(
  parameter int QUOTA     = 128,
  parameter int AF_THRESH = 252
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic [3:0]  in_valid,
  output logic [3:0]  in_ready,
  input  logic [35:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_data,
  output logic [1:0]  out_src,
  output logic [10:0] fifo_data,
  output logic        fifo_wrreq,
  output logic        fifo_rdreq,
  output logic        fifo_aclr,
  input  logic [10:0] fifo_q,
  input  logic [7:0]  fifo_usedw,
  input  logic        fifo_full,
`ifdef FIFO_ARB_STATS_EN
  output logic [63:0] grant_cnt,
`endif
  input  logic        fifo_empty
);

  localparam logic [8:0] c_quota     = 9'(QUOTA);
  localparam logic [7:0] c_af_thresh = 8'(AF_THRESH);

  logic       w_room;
  logic       w_pop;
  logic [3:0] w_elig;
  logic       w_found;
  logic [1:0] w_win;
  logic [8:0] w_payload [4];

  logic [1:0]  r_last;
  logic        r_wrreq;
  logic [10:0] r_data;
  logic        r_aclr;

  // The in-flight write is absorbed by the headroom below AF_THRESH.
  assign w_room = !fifo_full && (fifo_usedw < c_af_thresh);
  assign w_pop  = out_ready && !fifo_empty;

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_q[8:0];
  assign out_src    = fifo_q[10:9];
  assign fifo_rdreq = w_pop;

  assign fifo_data  = r_data;
  assign fifo_wrreq = r_wrreq;
  assign fifo_aclr  = r_aclr;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_src
      logic [8:0] r_occ;
      logic       w_inc;
      logic       w_dec;

      assign w_payload[i] = in_data[9*i +: 9];
      assign w_elig[i]    = in_valid[i] && (r_occ < c_quota) && w_room && !sclr;
      assign w_inc        = w_found && (w_win == 2'(i));
      assign w_dec        = w_pop && (fifo_q[10:9] == 2'(i));

      always_ff @(posedge clock) begin
        if (sclr) begin
          r_occ <= '0;
        end else if (w_inc && !w_dec) begin
          r_occ <= r_occ + 9'd1;
        end else if (w_dec && !w_inc && (r_occ != 9'd0)) begin
          r_occ <= r_occ - 9'd1;
        end
      end
    end
  endgenerate

  // Search order last+1 .. last+4; the 2-bit sum wraps modulo 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_elig[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last + 2'(k);
      end
    end
  end

  assign in_ready = w_found ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clock) begin
    r_aclr <= sclr;
    if (sclr) begin
      r_last  <= 2'd3;
      r_wrreq <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wrreq <= w_found;
      if (w_found) begin
        r_last <= w_win;
        r_data <= {w_win, w_payload[w_win]};
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar i = 0; i < 4; i++) begin : g_stats
      logic [15:0] r_cnt;

      assign grant_cnt[16*i +: 16] = r_cnt;

      always_ff @(posedge clock) begin
        if (sclr) begin
          r_cnt <= '0;
        end else if (w_found && (w_win == 2'(i)) && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  endgenerate
`endif

endmodule
`default_nettype wire
